// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register index, hazard controller state, counter width.
// Pure declarations; no logic.
package cpu_types_pkg;
  localparam int REGW_DEF = 5;
  localparam int HZ_CNT_W = 16;

  typedef logic [REGW_DEF-1:0] regbits_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LU    = 2'd1,
    MWAIT = 2'd2
  } hz_state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard controller signals; hc side drives enables, tb side drives pipeline status.
// No storage; zero latency.
interface hazard_ctrl_if #(
  parameter int REGW  = 5,
  parameter int CNT_W = 16
);
  logic            nRST;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            ex_lw;
  logic [REGW-1:0] ex_wsel;
  logic            ihit;
  logic            mem_req;
  logic            dhit;
  logic            ex_br_taken;
  logic            pc_en;
  logic            ifid_en;
  logic            idex_en;
  logic            exmem_en;
  logic            memwb_en;
  logic            ifid_flush;
  logic            idex_flush;
  logic [CNT_W-1:0] lu_stall_cnt;
  logic [CNT_W-1:0] mem_stall_cnt;

  modport hc (
    input  nRST, id_rs, id_rt, id_use_rs, id_use_rt, ex_lw, ex_wsel,
           ihit, mem_req, dhit, ex_br_taken,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           lu_stall_cnt, mem_stall_cnt
  );

  modport tb (
    output nRST, id_rs, id_rt, id_use_rs, id_use_rt, ex_lw, ex_wsel,
           ihit, mem_req, dhit, ex_br_taken,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           lu_stall_cnt, mem_stall_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; count updates one cycle after inc.
// Holds at all-ones instead of wrapping; clear wins over inc.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flush, dmem freeze, fetch-miss hold.
// Outputs are combinational from inputs and registered state (zero latency); mem wait freezes all latches.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REGW     = 5,
  parameter int LU_STALL = 1,
  parameter int CNT_W    = HZ_CNT_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [REGW-1:0]  id_rs,
  input  logic [REGW-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_lw,
  input  logic [REGW-1:0]  ex_wsel,
  input  logic             ihit,
  input  logic             mem_req,
  input  logic             dhit,
  input  logic             ex_br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_LU    = 2'(LU);
  localparam logic [1:0] S_MWAIT = 2'(MWAIT);
  localparam logic [1:0] LU_LOAD = 2'(LU_STALL - 1);

  logic [1:0] state, state_nxt, eff_state;
  logic [1:0] cnt, cnt_nxt;
  logic       lu_hz, mem_wait, lu_inc, mem_inc;
  logic [6:0] ctl;

  assign lu_hz = ex_lw && (ex_wsel != '0) &&
                 ((id_use_rs && (id_rs == ex_wsel)) || (id_use_rt && (id_rt == ex_wsel)));
  assign mem_wait = mem_req && !dhit;

  // Leaving MWAIT behaves exactly like the state that was frozen, recovered from cnt.
  assign eff_state = (state == S_MWAIT) ? ((cnt != 2'd0) ? S_LU : S_IDLE) : state;

  always_comb begin
    ctl       = 7'b1111100;
    state_nxt = S_IDLE;
    cnt_nxt   = cnt;
    lu_inc    = 1'b0;
    mem_inc   = 1'b0;
    if (mem_wait) begin
      ctl       = 7'b0000000;
      state_nxt = S_MWAIT;
      mem_inc   = 1'b1;
    end else if (ex_br_taken) begin
      ctl       = 7'b1111111;
      cnt_nxt   = 2'd0;
    end else if ((eff_state == S_LU) || lu_hz) begin
      ctl    = 7'b0011101;
      lu_inc = 1'b1;
      if (eff_state == S_LU) begin
        cnt_nxt   = cnt - 2'd1;
        state_nxt = (cnt == 2'd1) ? S_IDLE : S_LU;
      end else if (LU_STALL > 1) begin
        cnt_nxt   = LU_LOAD;
        state_nxt = S_LU;
      end
    end else if (!ihit) begin
      ctl = 7'b0111110;
    end
    if (!nRST) begin
      ctl = 7'b0000000;
    end
  end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} = ctl;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk   (CLK),
    .clear (!nRST),
    .inc   (lu_inc),
    .count (lu_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
    .clk   (CLK),
    .clear (!nRST),
    .inc   (mem_inc),
    .count (mem_stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed check of three hazard_ctrl configurations against a behavioural model.
module tb_hazard_ctrl;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  hazard_ctrl_if #(.REGW(5), .CNT_W(16)) hif ();

  logic        pc_b, ifid_b, idex_b, exmem_b, memwb_b, ifidf_b, idexf_b;
  logic        pc_c, ifid_c, idex_c, exmem_c, memwb_c, ifidf_c, idexf_c;
  logic [15:0] luc_b, memc_b;
  logic [3:0]  luc_c, memc_c;

  hazard_ctrl #(.REGW(5), .LU_STALL(1), .CNT_W(16)) dut_a (
    .CLK(CLK), .nRST(hif.nRST), .id_rs(hif.id_rs), .id_rt(hif.id_rt),
    .id_use_rs(hif.id_use_rs), .id_use_rt(hif.id_use_rt), .ex_lw(hif.ex_lw),
    .ex_wsel(hif.ex_wsel), .ihit(hif.ihit), .mem_req(hif.mem_req), .dhit(hif.dhit),
    .ex_br_taken(hif.ex_br_taken), .pc_en(hif.pc_en), .ifid_en(hif.ifid_en),
    .idex_en(hif.idex_en), .exmem_en(hif.exmem_en), .memwb_en(hif.memwb_en),
    .ifid_flush(hif.ifid_flush), .idex_flush(hif.idex_flush),
    .lu_stall_cnt(hif.lu_stall_cnt), .mem_stall_cnt(hif.mem_stall_cnt));

  hazard_ctrl #(.REGW(5), .LU_STALL(3), .CNT_W(16)) dut_b (
    .CLK(CLK), .nRST(hif.nRST), .id_rs(hif.id_rs), .id_rt(hif.id_rt),
    .id_use_rs(hif.id_use_rs), .id_use_rt(hif.id_use_rt), .ex_lw(hif.ex_lw),
    .ex_wsel(hif.ex_wsel), .ihit(hif.ihit), .mem_req(hif.mem_req), .dhit(hif.dhit),
    .ex_br_taken(hif.ex_br_taken), .pc_en(pc_b), .ifid_en(ifid_b), .idex_en(idex_b),
    .exmem_en(exmem_b), .memwb_en(memwb_b), .ifid_flush(ifidf_b), .idex_flush(idexf_b),
    .lu_stall_cnt(luc_b), .mem_stall_cnt(memc_b));

  hazard_ctrl #(.REGW(5), .LU_STALL(2), .CNT_W(4)) dut_c (
    .CLK(CLK), .nRST(hif.nRST), .id_rs(hif.id_rs), .id_rt(hif.id_rt),
    .id_use_rs(hif.id_use_rs), .id_use_rt(hif.id_use_rt), .ex_lw(hif.ex_lw),
    .ex_wsel(hif.ex_wsel), .ihit(hif.ihit), .mem_req(hif.mem_req), .dhit(hif.dhit),
    .ex_br_taken(hif.ex_br_taken), .pc_en(pc_c), .ifid_en(ifid_c), .idex_en(idex_c),
    .exmem_en(exmem_c), .memwb_en(memwb_c), .ifid_flush(ifidf_c), .idex_flush(idexf_c),
    .lu_stall_cnt(luc_c), .mem_stall_cnt(memc_c));

  int total = 0;
  int bad   = 0;

  // Model: bubbles still owed after this cycle, and plain integer counters.
  int lus[3]  = '{1, 3, 2};
  int cmax[3] = '{65535, 65535, 15};
  int rem[3]  = '{0, 0, 0};
  int m_lu[3] = '{0, 0, 0};
  int m_mem[3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_ctl(input int i);
    case (i)
      0: return {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                 hif.ifid_flush, hif.idex_flush};
      1: return {pc_b, ifid_b, idex_b, exmem_b, memwb_b, ifidf_b, idexf_b};
      default: return {pc_c, ifid_c, idex_c, exmem_c, memwb_c, ifidf_c, idexf_c};
    endcase
  endfunction

  function automatic logic [31:0] dut_lu(input int i);
    case (i)
      0: return 32'(hif.lu_stall_cnt);
      1: return 32'(luc_b);
      default: return 32'(luc_c);
    endcase
  endfunction

  function automatic logic [31:0] dut_mem(input int i);
    case (i)
      0: return 32'(hif.mem_stall_cnt);
      1: return 32'(memc_b);
      default: return 32'(memc_c);
    endcase
  endfunction

  task automatic set_normal();
    hif.nRST = 1'b1; hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_use_rs = 1'b0;
    hif.id_use_rt = 1'b0; hif.ex_lw = 1'b0; hif.ex_wsel = 5'd0; hif.ihit = 1'b1;
    hif.mem_req = 1'b0; hif.dhit = 1'b0; hif.ex_br_taken = 1'b0;
  endtask

  task automatic set_hazard();
    hif.ex_lw = 1'b1; hif.ex_wsel = 5'd8; hif.id_rs = 5'd8; hif.id_use_rs = 1'b1;
  endtask

  // Inputs are set just after a falling edge; check mid-cycle, advance model, go to next falling edge.
  task automatic cycle();
    logic [6:0] exp;
    bit hz;
    #1;
    hz = hif.ex_lw && (hif.ex_wsel != 0) &&
         ((hif.id_use_rs && hif.id_rs == hif.ex_wsel) || (hif.id_use_rt && hif.id_rt == hif.ex_wsel));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lu_cnt%0d", i), dut_lu(i), 32'(m_lu[i]));
      check($sformatf("mem_cnt%0d", i), dut_mem(i), 32'(m_mem[i]));
      if (!hif.nRST) begin
        exp = 7'b0000000; rem[i] = 0; m_lu[i] = 0; m_mem[i] = 0;
      end else if (hif.mem_req && !hif.dhit) begin
        exp = 7'b0000000;
        if (m_mem[i] < cmax[i]) m_mem[i]++;
      end else if (hif.ex_br_taken) begin
        exp = 7'b1111111; rem[i] = 0;
      end else if (rem[i] > 0 || hz) begin
        exp = 7'b0011101;
        if (m_lu[i] < cmax[i]) m_lu[i]++;
        rem[i] = (rem[i] > 0) ? rem[i] - 1 : lus[i] - 1;
      end else if (!hif.ihit) begin
        exp = 7'b0111110;
      end else begin
        exp = 7'b1111100;
      end
      check($sformatf("ctl%0d", i), 32'(dut_ctl(i)), 32'(exp));
    end
    @(negedge CLK);
  endtask

  task automatic idle_cycles(input int n);
    set_normal();
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    set_normal();
    hif.nRST = 1'b0;
    @(negedge CLK);
    cycle(); cycle();
    idle_cycles(2);
    check("reset_lu_b", 32'(luc_b), 32'd0);

    // Single load-use hazard.
    set_normal(); set_hazard(); cycle();
    idle_cycles(4);
    check("lu_once_a", 32'(hif.lu_stall_cnt), 32'd1);
    check("lu_once_b", 32'(luc_b), 32'd3);

    // Register 0 and unused operand never hazard.
    set_normal(); set_hazard(); hif.ex_wsel = 5'd0; hif.id_rs = 5'd0; cycle();
    set_normal(); set_hazard(); hif.id_use_rs = 1'b0; cycle();
    idle_cycles(3);
    check("no_hz_b", 32'(luc_b), 32'd3);

    // Memory wait in the middle of a load-use stall.
    set_normal(); set_hazard(); cycle();
    set_normal(); hif.mem_req = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    idle_cycles(4);
    check("mwait_mem_b", 32'(memc_b), 32'd4);
    check("mwait_lu_b", 32'(luc_b), 32'd6);

    // Branch taken with a wrong-path hazard.
    set_normal(); set_hazard(); hif.ex_br_taken = 1'b1; cycle();
    idle_cycles(3);
    check("br_lu_b", 32'(luc_b), 32'd6);

    // Fetch miss.
    set_normal(); hif.ihit = 1'b0; cycle(); cycle();

    // Long hazard run saturates the narrow counter.
    set_normal(); set_hazard();
    for (int k = 0; k < 20; k++) cycle();
    idle_cycles(3);
    check("sat_lu_c", 32'(luc_c), 32'd15);

    // Reset in the middle of an LU stall.
    set_normal(); set_hazard(); cycle();
    set_normal(); hif.nRST = 1'b0; cycle();
    idle_cycles(2);
    check("rst_lu_b", 32'(luc_b), 32'd0);
    check("rst_mem_b", 32'(memc_b), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      hif.nRST        = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      hif.ex_lw       = 1'($urandom_range(0, 1));
      hif.ex_wsel     = 5'($urandom_range(0, 3));
      hif.id_rs       = 5'($urandom_range(0, 3));
      hif.id_rt       = 5'($urandom_range(0, 3));
      hif.id_use_rs   = 1'($urandom_range(0, 1));
      hif.id_use_rt   = 1'($urandom_range(0, 1));
      hif.ihit        = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
      hif.mem_req     = ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0;
      hif.dhit        = 1'($urandom_range(0, 1));
      hif.ex_br_taken = ($urandom_range(0, 9) < 1) ? 1'b1 : 1'b0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
